// File: rtl/lm32_include.sv
// Shared LatticeMico32 constants: datapath width and load/store size encodings.
package lm32_include;

    localparam int LM32_WORD_WIDTH = 32;
    // MSB index of a datapath word; declare words as [LM32_WORD_RNG:0].
    localparam int LM32_WORD_RNG   = LM32_WORD_WIDTH - 1;

    localparam logic [1:0] LM32_SIZE_BYTE  = 2'b00;
    localparam logic [1:0] LM32_SIZE_HWORD = 2'b01;
    localparam logic [1:0] LM32_SIZE_WORD  = 2'b10;

endpackage

// File: rtl/lm32_load_align.sv
// Big-endian load alignment with sign/zero extension; purely combinational.
module lm32_load_align
    import lm32_include::*;
(
    input  logic [LM32_WORD_RNG:0] data,
    input  logic [1:0]             size,
    input  logic [1:0]             addr,
    input  logic                   sign_extend,
    output logic [LM32_WORD_RNG:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        byte_sel = data[31:24];
        half_sel = data[31:16];
        result   = data;

        case (addr)
            2'd0:    byte_sel = data[31:24];
            2'd1:    byte_sel = data[23:16];
            2'd2:    byte_sel = data[15:8];
            default: byte_sel = data[7:0];
        endcase

        half_sel = addr[1] ? data[15:0] : data[31:16];

        case (size)
            LM32_SIZE_BYTE:  result = {{24{sign_extend & byte_sel[7]}}, byte_sel};
            LM32_SIZE_HWORD: result = {{16{sign_extend & half_sel[15]}}, half_sel};
            default:         result = data;
        endcase
    end

endmodule

// File: rtl/lm32_m_result.sv
// M-stage result select, load-data acknowledge handshake and M->W pipeline register.
module lm32_m_result
    import lm32_include::*;
#(
    parameter int WORD_WIDTH = LM32_WORD_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  stall_m,
    input  logic                  kill_m,
    input  logic                  valid_m,
    input  logic                  shift_op_m,
    input  logic [WORD_WIDTH-1:0] shifter_result_m,
    input  logic [WORD_WIDTH-1:0] operand_m,
    input  logic                  load_m,
    input  logic [1:0]            size_m,
    input  logic                  sign_extend_m,
    input  logic [1:0]            addr_m,
    input  logic                  d_ack_i,
    input  logic [WORD_WIDTH-1:0] d_dat_i,
    input  logic                  write_enable_m,
    input  logic [4:0]            write_idx_m,
    output logic                  load_pending_m,
    output logic [WORD_WIDTH-1:0] result_w,
    output logic                  write_enable_w,
    output logic [4:0]            write_idx_w,
    output logic                  valid_w
);

    logic [WORD_WIDTH-1:0] load_buf;
    logic                  load_done;
    logic                  discard_ack;

    logic                  outstanding;
    logic                  ack_accepted;
    logic [WORD_WIDTH-1:0] load_raw;
    logic [WORD_WIDTH-1:0] load_data;
    logic [WORD_WIDTH-1:0] result_m;

    assign outstanding    = valid_m & load_m & ~load_done;
    assign ack_accepted   = d_ack_i & ~discard_ack & outstanding;
    assign load_pending_m = outstanding & (~d_ack_i | discard_ack);
    assign load_raw       = d_ack_i ? d_dat_i : load_buf;

    lm32_load_align u_load_align (
        .data        (load_raw),
        .size        (size_m),
        .addr        (addr_m),
        .sign_extend (sign_extend_m),
        .result      (load_data)
    );

    always_comb begin
        result_m = operand_m;
        if (load_m)
            result_m = load_data;
        else if (shift_op_m)
            result_m = shifter_result_m;
    end

    // A killed load's bus cycle still completes, so its ack must be swallowed later.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_i) begin
            load_buf    <= '0;
            load_done   <= 1'b0;
            discard_ack <= 1'b0;
        end else begin
            if (ack_accepted && stall_m)
                load_buf <= d_dat_i;

            if (kill_m || !stall_m)
                load_done <= 1'b0;
            else if (ack_accepted)
                load_done <= 1'b1;

            if (kill_m && outstanding && !ack_accepted)
                discard_ack <= 1'b1;
            else if (d_ack_i && discard_ack)
                discard_ack <= 1'b0;
        end
    end

    // Bubbles leave result_w and write_idx_w untouched; only the strobes drop.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            result_w       <= '0;
            write_idx_w    <= '0;
            write_enable_w <= 1'b0;
            valid_w        <= 1'b0;
        end else if (stall_m || kill_m || !valid_m) begin
            write_enable_w <= 1'b0;
            valid_w        <= 1'b0;
        end else begin
            result_w       <= result_m;
            write_idx_w    <= write_idx_m;
            write_enable_w <= write_enable_m;
            valid_w        <= 1'b1;
        end
    end

endmodule

// File: tb/tb_lm32_m_result.sv
// Directed bench for lm32_m_result: select, alignment, handshake, kill/discard, reset and bubbles.
module tb_lm32_m_result;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stall_m;
    logic        kill_m;
    logic        valid_m;
    logic        shift_op_m;
    logic [31:0] shifter_result_m;
    logic [31:0] operand_m;
    logic        load_m;
    logic [1:0]  size_m;
    logic        sign_extend_m;
    logic [1:0]  addr_m;
    logic        d_ack_i;
    logic [31:0] d_dat_i;
    logic        write_enable_m;
    logic [4:0]  write_idx_m;
    logic        load_pending_m;
    logic [31:0] result_w;
    logic        write_enable_w;
    logic [4:0]  write_idx_w;
    logic        valid_w;

    int tests_run = 0;
    int tests_failed = 0;

    lm32_m_result #(.WORD_WIDTH(32)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .stall_m          (stall_m),
        .kill_m           (kill_m),
        .valid_m          (valid_m),
        .shift_op_m       (shift_op_m),
        .shifter_result_m (shifter_result_m),
        .operand_m        (operand_m),
        .load_m           (load_m),
        .size_m           (size_m),
        .sign_extend_m    (sign_extend_m),
        .addr_m           (addr_m),
        .d_ack_i          (d_ack_i),
        .d_dat_i          (d_dat_i),
        .write_enable_m   (write_enable_m),
        .write_idx_m      (write_idx_m),
        .load_pending_m   (load_pending_m),
        .result_w         (result_w),
        .write_enable_w   (write_enable_w),
        .write_idx_w      (write_idx_w),
        .valid_w          (valid_w)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance one edge, then leave 1 time unit before driving or sampling.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst_i = 1'b0; stall_m = 1'b0; kill_m = 1'b0; valid_m = 1'b0;
        shift_op_m = 1'b0; shifter_result_m = '0; operand_m = '0;
        load_m = 1'b0; size_m = 2'b10; sign_extend_m = 1'b0; addr_m = 2'd0;
        d_ack_i = 1'b0; d_dat_i = '0; write_enable_m = 1'b0; write_idx_m = '0;

        tick(); tick();
        check("rst_result_w", result_w, 32'h0);
        check("rst_valid_w", {31'b0, valid_w}, 32'h0);
        check("rst_we_w", {31'b0, write_enable_w}, 32'h0);
        check("rst_idx_w", {27'b0, write_idx_w}, 32'h0);
        check("rst_pending", {31'b0, load_pending_m}, 32'h0);
        rst_i = 1'b1;

        // Shift select beats operand
        valid_m = 1'b1; shift_op_m = 1'b1; shifter_result_m = 32'hF000_0001;
        operand_m = 32'h0000_1111; write_idx_m = 5'd5; write_enable_m = 1'b1;
        tick();
        check("shift_result", result_w, 32'hF000_0001);
        check("shift_idx", {27'b0, write_idx_w}, 32'd5);
        check("shift_valid", {31'b0, valid_w}, 32'h1);
        check("shift_we", {31'b0, write_enable_w}, 32'h1);

        // Operand select
        shift_op_m = 1'b0; operand_m = 32'h1234_5678; write_idx_m = 5'd6;
        tick();
        check("operand_result", result_w, 32'h1234_5678);
        check("operand_idx", {27'b0, write_idx_w}, 32'd6);

        // Signed byte load, ack in advancing cycle; load beats shift
        shift_op_m = 1'b1; load_m = 1'b1; size_m = 2'b00; addr_m = 2'd1; sign_extend_m = 1'b1;
        d_ack_i = 1'b1; d_dat_i = 32'h1280_3456;
        settle();
        check("sbyte_pending", {31'b0, load_pending_m}, 32'h0);
        tick();
        check("sbyte_result", result_w, 32'hFFFF_FF80);

        addr_m = 2'd3; sign_extend_m = 1'b0;
        tick();
        check("ubyte3_result", result_w, 32'h0000_0056);

        size_m = 2'b01; addr_m = 2'd0; sign_extend_m = 1'b1; d_dat_i = 32'h8001_7FFF;
        tick();
        check("shalf0_result", result_w, 32'hFFFF_8001);

        size_m = 2'b11; addr_m = 2'd2; d_dat_i = 32'hA5A5_0F0F;
        tick();
        check("word_result", result_w, 32'hA5A5_0F0F);
        shift_op_m = 1'b0;

        // Half load acked during an unrelated stall
        size_m = 2'b01; addr_m = 2'd2; sign_extend_m = 1'b0; d_ack_i = 1'b0;
        d_dat_i = 32'hFFFF_FFFF; stall_m = 1'b1; write_idx_m = 5'd7;
        settle();
        check("half_pending_noack", {31'b0, load_pending_m}, 32'h1);
        tick();
        check("half_stall_bubble", {31'b0, valid_w}, 32'h0);
        d_ack_i = 1'b1; d_dat_i = 32'hABCD_1234;
        settle();
        check("half_pending_ack", {31'b0, load_pending_m}, 32'h0);
        tick();
        d_ack_i = 1'b0; d_dat_i = 32'hFFFF_FFFF;
        settle();
        check("half_pending_n1", {31'b0, load_pending_m}, 32'h0);
        tick();
        check("half_pending_n2", {31'b0, load_pending_m}, 32'h0);
        check("half_hold_result", result_w, 32'hA5A5_0F0F);
        tick();
        stall_m = 1'b0;
        tick();
        check("half_buf_result", result_w, 32'h0000_1234);
        check("half_buf_idx", {27'b0, write_idx_w}, 32'd7);
        check("half_buf_valid", {31'b0, valid_w}, 32'h1);

        // Kill an outstanding load; its late ack must be discarded
        size_m = 2'b10; addr_m = 2'd0; stall_m = 1'b1; kill_m = 1'b1;
        settle();
        check("kill_pending", {31'b0, load_pending_m}, 32'h1);
        tick();
        check("kill_bubble", {31'b0, valid_w}, 32'h0);
        kill_m = 1'b0;
        settle();
        check("next_pending", {31'b0, load_pending_m}, 32'h1);
        tick();
        d_ack_i = 1'b1; d_dat_i = 32'hDEAD_BEEF;
        settle();
        check("discard_pending", {31'b0, load_pending_m}, 32'h1);
        tick();
        d_ack_i = 1'b0;
        check("discard_not_in_w", result_w, 32'h0000_1234);
        check("discard_bubble", {31'b0, valid_w}, 32'h0);
        settle();
        check("after_discard_pending", {31'b0, load_pending_m}, 32'h1);
        tick();
        d_ack_i = 1'b1; d_dat_i = 32'h0000_0007; stall_m = 1'b0;
        settle();
        check("own_ack_pending", {31'b0, load_pending_m}, 32'h0);
        tick();
        d_ack_i = 1'b0;
        check("own_ack_result", result_w, 32'h0000_0007);
        check("own_ack_valid", {31'b0, valid_w}, 32'h1);

        // Reset in the middle of an outstanding load
        stall_m = 1'b1;
        settle();
        check("prereset_pending", {31'b0, load_pending_m}, 32'h1);
        rst_i = 1'b0;
        tick();
        rst_i = 1'b1; valid_m = 1'b0; load_m = 1'b0; stall_m = 1'b0;
        settle();
        check("midrst_result", result_w, 32'h0);
        check("midrst_idx", {27'b0, write_idx_w}, 32'h0);
        check("midrst_we", {31'b0, write_enable_w}, 32'h0);
        check("midrst_valid", {31'b0, valid_w}, 32'h0);
        check("midrst_pending", {31'b0, load_pending_m}, 32'h0);
        tick();
        check("midrst_pending_idle", {31'b0, load_pending_m}, 32'h0);
        valid_m = 1'b1; load_m = 1'b1; d_ack_i = 1'b1; d_dat_i = 32'hCAFE_F00D; write_idx_m = 5'd3;
        settle();
        check("postrst_pending", {31'b0, load_pending_m}, 32'h0);
        tick();
        d_ack_i = 1'b0; load_m = 1'b0;
        check("postrst_result", result_w, 32'hCAFE_F00D);

        // Stall then kill bubbles hold result_w
        operand_m = 32'h55AA_55AA; write_idx_m = 5'd9;
        tick();
        check("pre_bubble_result", result_w, 32'h55AA_55AA);
        operand_m = 32'h1111_1111; write_idx_m = 5'd10; stall_m = 1'b1;
        tick();
        check("stall1_we", {31'b0, write_enable_w}, 32'h0);
        check("stall1_result", result_w, 32'h55AA_55AA);
        tick();
        check("stall2_we", {31'b0, write_enable_w}, 32'h0);
        check("stall2_idx", {27'b0, write_idx_w}, 32'd9);
        stall_m = 1'b0; kill_m = 1'b1;
        tick();
        check("kill_we", {31'b0, write_enable_w}, 32'h0);
        check("kill_result", result_w, 32'h55AA_55AA);
        stall_m = 1'b1;
        tick();
        check("kill_stall_valid", {31'b0, valid_w}, 32'h0);

        // Kill and ack together: ack consumed, no discard left behind
        stall_m = 1'b0; load_m = 1'b1; d_ack_i = 1'b1; d_dat_i = 32'h0BAD_0BAD;
        tick();
        check("killack_valid", {31'b0, valid_w}, 32'h0);
        check("killack_result", result_w, 32'h55AA_55AA);
        kill_m = 1'b0; d_dat_i = 32'h0000_0042;
        settle();
        check("killack_no_discard", {31'b0, load_pending_m}, 32'h0);
        tick();
        d_ack_i = 1'b0; valid_m = 1'b0; load_m = 1'b0;
        check("killack_next_result", result_w, 32'h0000_0042);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/lm32_m_result.md
# lm32_m_result

M-stage result-select and M→W pipeline register for the LatticeMico32 core. It sits directly downstream of the barrel shifter and consumes its registered output `shifter_result_m`. Each cycle it picks between the shifter result, the generic M-stage operand, and big-endian-aligned load data. It also runs the load-data acknowledge handshake, which includes a holding register for data that arrives while the pipeline is stalled. The selected result is registered into W for register-file writeback.

## Interface
- `WORD_WIDTH`, default 32: datapath width; only 32 is supported.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset. One clock; reset is synchronous and active-low.
- `stall_m` in 1: M stage held this cycle. Already includes `load_pending_m` via pipeline control.
- `kill_m` in 1: flush the M-stage instruction.
- `valid_m` in 1: M holds a live instruction.
- `shift_op_m` in 1: instruction is a shift; select `shifter_result_m`.
- `shifter_result_m` in 32: barrel shifter result.
- `operand_m` in 32: ALU or other M-stage result.
- `load_m` in 1: instruction is a load.
- `size_m` in 2: load size. 00 = byte, 01 = half, 1x = word.
- `sign_extend_m` in 1: sign-extend byte/half loads.
- `addr_m` in 2: low address bits of the load.
- `d_ack_i` in 1: data bus acknowledge, single-cycle pulse.
- `d_dat_i` in 32: data bus read data, valid with `d_ack_i`.
- `write_enable_m` in 1: instruction writes the register file.
- `write_idx_m` in 5: destination register.
- `load_pending_m` out 1: stall request while the load's data is outstanding.
- `result_w` out 32: registered writeback data.
- `write_enable_w` out 1: registered register-file write strobe.
- `write_idx_w` out 5: registered destination register.
- `valid_w` out 1: W holds a live instruction.

## Operation
- Select priority: `load_m` first, then `shift_op_m`, then `operand_m`.
- Load alignment is big-endian.
  - Byte: offset 0 → [31:24], 1 → [23:16], 2 → [15:8], 3 → [7:0].
  - Half: `addr_m[1]`=0 → [31:16], 1 → [15:0]. `addr_m[0]` is ignored.
  - Word: data passes unchanged; `addr_m` is ignored.
  - Fill: zero-fill, or copy the field's MSB when `sign_extend_m`=1.
- Load source: raw `d_dat_i` when `d_ack_i`=1 this cycle, otherwise the holding register `load_buf`.
- Load handshake uses three registers: `load_buf`, `load_done`, `discard_ack`. An outstanding load means `valid_m & load_m & ~load_done`.
  - `load_pending_m` = outstanding & (~`d_ack_i` | `discard_ack`). It is combinational.
  - On `d_ack_i` with `discard_ack`=0, an outstanding load and `stall_m`=1: capture `d_dat_i` into `load_buf` and set `load_done`.
  - On `d_ack_i` with `discard_ack`=1: clear `discard_ack` and ignore the data.
  - On `kill_m` with an outstanding load and no accepted ack this cycle: set `discard_ack`. The bus transaction is not aborted, so its later ack must be dropped.
  - `load_done` clears when M advances (`stall_m`=0) or on `kill_m`.
- W register updates every cycle.
  - If `stall_m`=1 or `kill_m`=1 or `valid_m`=0: load a bubble (`valid_w`=0, `write_enable_w`=0). `result_w` and `write_idx_w` hold their values.
  - Otherwise: `result_w` ← selected result, `write_idx_w` ← `write_idx_m`, `write_enable_w` ← `write_enable_m`, `valid_w` ← 1.
- Reset (`rst_i`=0 at a rising edge) clears `result_w`, `write_idx_w`, `write_enable_w`, `valid_w`, `load_buf`, `load_done` and `discard_ack` to 0.
  - `load_pending_m` therefore reads 0 after reset until a load enters M.
  - A reset during an outstanding load drops that load; no discard state survives reset.

## Timing
- Non-load result: `result_w` is valid one cycle after the cycle in which M advances.
- Load with ack in the advancing cycle: `d_dat_i` is aligned combinationally and registered into W at that edge, for zero extra latency.
- Load with ack during an unrelated stall: data is held in `load_buf`, and `load_pending_m` drops in the cycle after capture. W is written at the first non-stalled edge.
- Simultaneous `kill_m` and `d_ack_i` for the same load: the ack is consumed, W gets a bubble, and `discard_ack` stays 0.
- Simultaneous `kill_m` and `stall_m`: kill wins and W gets a bubble.
- A new load entering M while `discard_ack`=1 keeps `load_pending_m` high through the discarded ack and clears on its own ack.

## Structure
- The shared package `lm32_include` holds:
  - the `LM32_WORD_RNG` and `LM32_WORD_WIDTH` constants;
  - the size encodings `LM32_SIZE_BYTE`, `LM32_SIZE_HWORD`, `LM32_SIZE_WORD`.
- Sub-module `lm32_load_align`: purely combinational align and sign/zero extend, with inputs (data, size, addr, sign_extend). It is reused by the debug memory path.
- The handshake registers and W register live in this module.

## Test plan
- Shift select: `shift_op_m`=1, `shifter_result_m`=0xF000_0001, `valid_m`=1, no stall, `write_idx_m`=5. Next cycle: `result_w`=0xF000_0001, `write_idx_w`=5, `valid_w`=1.
- Signed byte load: `d_dat_i`=0x1280_3456, size=byte, addr=1, sign_extend=1, ack in the advancing cycle. Next cycle: `result_w`=0xFFFF_FF80. With addr=3 and zero-extend: 0x0000_0056.
- Half load during an unrelated stall: ack at cycle N with `stall_m`=1 from another source, data 0xABCD_1234, addr=2; stall released at N+3. `load_pending_m`=0 from N+1, and `result_w`=0x0000_1234 at N+4.
- Kill of an outstanding load: kill at cycle N with no ack; the next load enters M; first ack carries 0xDEAD_BEEF, second ack carries 0x0000_0007 (word). `result_w`=7, and the discarded data never appears in W.
- Reset mid-load: `rst_i`=0 for one cycle while `load_pending_m`=1. All outputs are 0 afterwards and `load_pending_m`=0 until a new load enters M.
- Stall and kill bubbles: `stall_m`=1 for 2 cycles, then `kill_m`=1 with `write_enable_m`=1. `write_enable_w`=0 throughout and `result_w` holds its prior value.
